// File: rtl/status_register.sv
// Five-flag processor status register {N,Z,C,B,V}: all flags load together on
// load_flags_en, hold otherwise, and return to RESET_FLAGS on synchronous reset.
module status_register #(
  parameter logic [4:0] RESET_FLAGS = 5'b00000
) (
  input  logic clk,
  input  logic reset,
  input  logic load_flags_en,
  input  logic n_in,
  input  logic z_in,
  input  logic c_in,
  input  logic b_in,
  input  logic v_in,
  output logic n_out,
  output logic z_out,
  output logic c_out,
  output logic b_out,
  output logic v_out
);

  logic [4:0] flags_q;
  logic [4:0] flags_d;

  // Whole-word load: the flags are never merged with their previous values.
  always_comb begin
    flags_d = flags_q;
    if (load_flags_en) begin
      flags_d = {n_in, z_in, c_in, b_in, v_in};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign n_out = flags_q[4];
  assign z_out = flags_q[3];
  assign c_out = flags_q[2];
  assign b_out = flags_q[1];
  assign v_out = flags_q[0];

endmodule

// File: tb/tb_status_register.sv
// Bench for status_register: directed flag patterns followed by random
// reset/load/hold traffic compared against a simple flag-word model.
module tb_status_register;

  localparam logic [4:0] RST_VAL = 5'b00000;

  logic clk;
  logic reset;
  logic load_flags_en;
  logic n_in, z_in, c_in, b_in, v_in;
  logic n_out, z_out, c_out, b_out, v_out;

  int vectors;
  int miscompares;
  logic [4:0] model_flags;

  status_register #(.RESET_FLAGS(RST_VAL)) dut (
    .clk          (clk),
    .reset        (reset),
    .load_flags_en(load_flags_en),
    .n_in         (n_in),
    .z_in         (z_in),
    .c_in         (c_in),
    .b_in         (b_in),
    .v_in         (v_in),
    .n_out        (n_out),
    .z_out        (z_out),
    .c_out        (c_out),
    .b_out        (b_out),
    .v_out        (v_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] dut_flags();
    return {n_out, z_out, c_out, b_out, v_out};
  endfunction

  task automatic check_flags(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic set_inputs(input logic rst, input logic en, input logic [4:0] flags);
    reset = rst;
    load_flags_en = en;
    {n_in, z_in, c_in, b_in, v_in} = flags;
  endtask

  // One transaction: drive at the falling edge, let one rising edge happen,
  // advance the model by the register's rules and check 1 time unit later.
  task automatic apply(input string tag, input logic rst, input logic en, input logic [4:0] flags);
    @(negedge clk);
    set_inputs(rst, en, flags);
    @(posedge clk);
    if (rst) model_flags = RST_VAL;
    else if (en) model_flags = flags;
    #1;
    $display("%-12s rst=%b en=%b in=%b out=%b", tag, rst, en, flags, dut_flags());
    check_flags(tag, dut_flags(), model_flags);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_flags = 5'bx;
    set_inputs(1'b0, 1'b0, 5'b00000);

    apply("reset", 1'b1, 1'b0, 5'b00000);
    check_flags("reset_zero", dut_flags(), 5'b00000);

    apply("load_10101", 1'b0, 1'b1, 5'b10101);
    check_flags("const_10101", dut_flags(), 5'b10101);
    apply("load_01010", 1'b0, 1'b1, 5'b01010);
    check_flags("overwrite", dut_flags(), 5'b01010);
    apply("load_11111", 1'b0, 1'b1, 5'b11111);
    check_flags("const_11111", dut_flags(), 5'b11111);
    apply("rst_after", 1'b1, 1'b0, 5'b11111);
    check_flags("reset_clear", dut_flags(), 5'b00000);

    apply("load_10101b", 1'b0, 1'b1, 5'b10101);
    for (int i = 0; i < 3; i++) begin
      apply("hold", 1'b0, 1'b0, 5'b01010);
      check_flags("hold_10101", dut_flags(), 5'b10101);
    end

    // Inputs, enable and reset toggling between edges must not reach the outputs.
    set_inputs(1'b1, 1'b1, 5'b01010);
    #2;
    check_flags("mid_cycle", dut_flags(), 5'b10101);

    apply("rst_vs_load", 1'b1, 1'b1, 5'b11111);
    check_flags("rst_priority", dut_flags(), 5'b00000);
    apply("first_load", 1'b0, 1'b1, 5'b11011);
    check_flags("no_recovery", dut_flags(), 5'b11011);
    apply("n_and_z", 1'b0, 1'b1, 5'b11000);

    for (int i = 0; i < 200; i++) begin
      apply("random", ($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/status_register.md
STATUS_REGISTER -- requirements
Module: status_register

Interface
- Parameters:
  - REQ-001 The module SHALL have parameter RESET_FLAGS, default 5'b00000, giving the {N,Z,C,B,V} value loaded on reset.
- Ports:
  - REQ-002 The module SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
  - REQ-003 The module SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
  - REQ-004 The module SHALL have port load_flags_en, input, 1 bit: when high at a rising edge, all five flags are captured from the *_in inputs.
  - REQ-005 The module SHALL have port n_in, input, 1 bit: next Negative flag.
  - REQ-006 The module SHALL have port z_in, input, 1 bit: next Zero flag.
  - REQ-007 The module SHALL have port c_in, input, 1 bit: next Carry flag.
  - REQ-008 The module SHALL have port b_in, input, 1 bit: next Borrow flag.
  - REQ-009 The module SHALL have port v_in, input, 1 bit: next Overflow flag.
  - REQ-010 The module SHALL have port n_out, output, 1 bit: registered Negative flag.
  - REQ-011 The module SHALL have port z_out, output, 1 bit: registered Zero flag.
  - REQ-012 The module SHALL have port c_out, output, 1 bit: registered Carry flag.
  - REQ-013 The module SHALL have port b_out, output, 1 bit: registered Borrow flag.
  - REQ-014 The module SHALL have port v_out, output, 1 bit: registered Overflow flag.

Function
- REQ-015 The module SHALL hold five independent 1-bit flip-flops, N, Z, C, B and V, each driving its *_out port directly.
- REQ-016 Outputs SHALL be purely registered, with no combinational path from any *_in or load_flags_en to any *_out.
- REQ-017 At a rising clk edge with reset=0 and load_flags_en=1, the module SHALL load all five flags simultaneously from n_in, z_in, c_in, b_in and v_in (all-or-nothing; no per-flag enables).
- REQ-018 Load latency SHALL be one clock: new values are visible on *_out immediately after the capturing edge and stable for the following cycle.
- REQ-019 At a rising clk edge with reset=0 and load_flags_en=0, the module SHALL hold all flags unchanged, regardless of *_in activity.
- REQ-020 Consecutive load cycles SHALL each overwrite all five flags, with no accumulation or ORing of old values.
- REQ-021 Flags SHALL be mutually independent: the register SHALL NOT enforce any consistency between flags (e.g. N=1 together with Z=1 is stored as given).
- REQ-022 Changes on *_in or load_flags_en between clock edges SHALL have no effect on *_out.

Reset
- REQ-023 Reset SHALL be synchronous: when reset=1 at a rising clk edge, {N,Z,C,B,V} SHALL become RESET_FLAGS (all 0 by default).
- REQ-024 Reset SHALL have priority over load: reset=1 and load_flags_en=1 at the same edge SHALL yield RESET_FLAGS.
- REQ-025 Asserting reset between clock edges SHALL NOT change the outputs until the next rising edge.
- REQ-026 Flag values before the first reset or load edge are undefined; the design SHALL NOT depend on initial register values.
- REQ-027 The first load_flags_en=1 edge after reset deassertion SHALL load normally, with no extra recovery cycle.

Verification
- REQ-028 The bench SHALL apply inputs 10101 ({N,Z,C,B,V}) with load_flags_en=1 for one edge, then load_flags_en=0, and require *_out = 10101 one time unit after the edge.
- REQ-029 The bench SHALL load 01010 directly after the 10101 load and require *_out = 01010, confirming a full overwrite.
- REQ-030 The bench SHALL load 11111 and require *_out = 11111.
- REQ-031 The bench SHALL hold reset=1 across one rising edge and require *_out = 00000 after that edge.
- REQ-032 The bench SHALL load 10101, then change inputs to 01010 with load_flags_en=0 for 3 edges, and require *_out to remain 10101.
- REQ-033 The bench SHALL set inputs to 11111 with reset=1 and load_flags_en=1 at the same edge, and require *_out = 00000 (reset priority).
